// File: rtl/uno_seq_if.sv
// uno_seq_if: request/response handshake bundle between the array
// controller (master) and the uno_seq sequencer (slave).
interface uno_seq_if #(
  parameter int MAC_BW = 12
) ();
  localparam int ACC_W = 2*MAC_BW+4;

  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [MAC_BW-1:0]     req_x;
  logic [MAC_BW-1:0]     req_y;
  logic [2*MAC_BW-1:0]   req_z;
  logic                  req_last;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ACC_W-1:0]      rsp_data;

  modport master (
    output req_valid, req_op, req_x, req_y,
    output req_z, req_last, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_x, req_y,
    input  req_z, req_last, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/uno_seq.sv
// uno_seq: control sequencer for the unified MAC/div/exp/log PE.
// Streams MAC beats or Horner steps to the PE and returns its result.
module uno_seq #(
  parameter int MAC_BW    = 12,
  parameter int MAX_TERMS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic                         cfg_len_we,
  input  logic [1:0]                   cfg_op,
  input  logic [$clog2(MAX_TERMS)-1:0] cfg_idx,
  input  logic [MAC_BW-1:0]            cfg_data,
  output logic                         cfg_ready,
  uno_seq_if.slave                     bus,
  output logic [1:0]                   pe_op,
  output logic [MAC_BW-1:0]            pe_x,
  output logic [MAC_BW-1:0]            pe_y,
  output logic [2*MAC_BW-1:0]          pe_z,
  output logic [MAC_BW-1:0]            pe_coeff,
  output logic                         pe_first_cycle,
  output logic                         pe_last_cycle,
  output logic                         pe_acc_en,
  input  logic [2*MAC_BW+3:0]          pe_out
);
  localparam int IW    = $clog2(MAX_TERMS);
  localparam int ACC_W = 2*MAC_BW+4;
  localparam logic [3:0] LMAX = 4'(MAX_TERMS);

  typedef enum logic [2:0] {
    IDLE, MAC_RUN, POLY, CAPT, RESP
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [MAC_BW-1:0]   x_q, x_d;
  logic [MAC_BW-1:0]   y_q, y_d;
  logic [3:0]          len_q, len_d;
  logic [3:0]          k_q, k_d;
  logic [3:0]          k_n;
  logic                drain_q, drain_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ACC_W-1:0]    rsp_data_q, rsp_data_d;
  logic [1:0]          pe_op_q, pe_op_d;
  logic [MAC_BW-1:0]   pe_x_q, pe_x_d;
  logic [MAC_BW-1:0]   pe_y_q, pe_y_d;
  logic [2*MAC_BW-1:0] pe_z_q, pe_z_d;
  logic [MAC_BW-1:0]   pe_coeff_q, pe_coeff_d;
  logic                pe_first_q, pe_first_d;
  logic                pe_last_q, pe_last_d;
  logic                pe_acc_en_q, pe_acc_en_d;
  logic [MAC_BW-1:0]   tab_q [4][MAX_TERMS];
  logic [MAC_BW-1:0]   tab_d [4][MAX_TERMS];
  logic [3:0]          len_tab_q [4];
  logic [3:0]          len_tab_d [4];
  logic                req_ready;
  logic                req_fire;
  logic [3:0]          len_raw;
  logic [3:0]          len_clamp;

  assign req_ready = (state_q == IDLE) || (state_q == MAC_RUN);
  assign req_fire  = bus.req_valid && req_ready;
  assign cfg_ready = (state_q == IDLE);
  assign len_raw   = cfg_data[3:0];
  assign len_clamp = (len_raw < 4'd2) ? 4'd2 :
                     (len_raw > LMAX) ? LMAX : len_raw;

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign pe_op          = pe_op_q;
  assign pe_x           = pe_x_q;
  assign pe_y           = pe_y_q;
  assign pe_z           = pe_z_q;
  assign pe_coeff       = pe_coeff_q;
  assign pe_first_cycle = pe_first_q;
  assign pe_last_cycle  = pe_last_q;
  assign pe_acc_en      = pe_acc_en_q;

  // Next-state, next PE drive and table updates; PE drive defaults to idle
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    x_d         = x_q;
    y_d         = y_q;
    len_d       = len_q;
    k_d         = k_q;
    drain_d     = drain_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    pe_op_d     = '0;
    pe_x_d      = '0;
    pe_y_d      = '0;
    pe_z_d      = '0;
    pe_coeff_d  = '0;
    pe_first_d  = 1'b0;
    pe_last_d   = 1'b0;
    pe_acc_en_d = 1'b0;
    tab_d       = tab_q;
    len_tab_d   = len_tab_q;
    k_n         = k_q + 4'd1;

    if (cfg_ready && cfg_op != 2'b00) begin
      if (cfg_we)     tab_d[cfg_op][cfg_idx] = cfg_data;
      if (cfg_len_we) len_tab_d[cfg_op] = len_clamp;
    end

    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          if (bus.req_op == 2'b00) begin
            pe_x_d  = bus.req_x;
            pe_y_d  = bus.req_y;
            pe_z_d  = bus.req_z;
            drain_d = bus.req_last;
            state_d = bus.req_last ? CAPT : MAC_RUN;
          end else begin
            op_d       = bus.req_op;
            x_d        = bus.req_x;
            y_d        = bus.req_y;
            len_d      = len_tab_q[bus.req_op];
            k_d        = '0;
            pe_op_d    = bus.req_op;
            pe_x_d     = bus.req_x;
            pe_y_d     = bus.req_y;
            pe_coeff_d = tab_q[bus.req_op][0];
            pe_first_d = 1'b1;
            state_d    = POLY;
          end
        end
      end
      MAC_RUN: begin
        pe_acc_en_d = 1'b1;
        if (req_fire) begin
          pe_x_d = bus.req_x;
          pe_y_d = bus.req_y;
          if (bus.req_last) begin
            drain_d = 1'b1;
            state_d = CAPT;
          end
        end
      end
      POLY: begin
        if (k_q == len_q - 4'd1) begin
          state_d = CAPT;
        end else begin
          k_d        = k_n;
          pe_op_d    = op_q;
          pe_x_d     = x_q;
          pe_y_d     = y_q;
          pe_coeff_d = tab_q[op_q][k_n[IW-1:0]];
          pe_last_d  = (k_n == len_q - 4'd1);
        end
      end
      CAPT: begin
        // The final MAC beat is still on the PE inputs; wait one cycle
        if (drain_q) begin
          drain_d = 1'b0;
        end else begin
          rsp_data_d  = pe_out;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, registered PE drive and coefficient tables
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      len_q       <= 4'd2;
      k_q         <= '0;
      drain_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      pe_op_q     <= '0;
      pe_x_q      <= '0;
      pe_y_q      <= '0;
      pe_z_q      <= '0;
      pe_coeff_q  <= '0;
      pe_first_q  <= 1'b0;
      pe_last_q   <= 1'b0;
      pe_acc_en_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        len_tab_q[i] <= 4'd2;
        for (int j = 0; j < MAX_TERMS; j++)
          tab_q[i][j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      x_q         <= x_d;
      y_q         <= y_d;
      len_q       <= len_d;
      k_q         <= k_d;
      drain_q     <= drain_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      pe_op_q     <= pe_op_d;
      pe_x_q      <= pe_x_d;
      pe_y_q      <= pe_y_d;
      pe_z_q      <= pe_z_d;
      pe_coeff_q  <= pe_coeff_d;
      pe_first_q  <= pe_first_d;
      pe_last_q   <= pe_last_d;
      pe_acc_en_q <= pe_acc_en_d;
      tab_q       <= tab_d;
      len_tab_q   <= len_tab_d;
    end
  end
endmodule

// File: tb/tb_uno_seq.sv
// tb_uno_seq: scoreboard bench for uno_seq with a behavioural PE.
// Expected results are queued at request time and popped on response.
module tb_uno_seq;
  localparam int MAC_BW    = 12;
  localparam int MAX_TERMS = 8;
  localparam int ACC_W     = 2*MAC_BW+4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cfg_we = 1'b0;
  logic                cfg_len_we = 1'b0;
  logic [1:0]          cfg_op = '0;
  logic [2:0]          cfg_idx = '0;
  logic [MAC_BW-1:0]   cfg_data = '0;
  logic                cfg_ready;
  logic [1:0]          pe_op;
  logic [MAC_BW-1:0]   pe_x;
  logic [MAC_BW-1:0]   pe_y;
  logic [2*MAC_BW-1:0] pe_z;
  logic [MAC_BW-1:0]   pe_coeff;
  logic                pe_first_cycle;
  logic                pe_last_cycle;
  logic                pe_acc_en;
  logic [ACC_W-1:0]    pe_out;

  uno_seq_if #(.MAC_BW(MAC_BW)) bus ();

  uno_seq #(.MAC_BW(MAC_BW), .MAX_TERMS(MAX_TERMS)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_we(cfg_we),
    .cfg_len_we(cfg_len_we),
    .cfg_op(cfg_op),
    .cfg_idx(cfg_idx),
    .cfg_data(cfg_data),
    .cfg_ready(cfg_ready),
    .bus(bus),
    .pe_op(pe_op),
    .pe_x(pe_x),
    .pe_y(pe_y),
    .pe_z(pe_z),
    .pe_coeff(pe_coeff),
    .pe_first_cycle(pe_first_cycle),
    .pe_last_cycle(pe_last_cycle),
    .pe_acc_en(pe_acc_en),
    .pe_out(pe_out)
  );

  always #5 clk = ~clk;

  // Behavioural PE: registered MAC, and a shift-add step for other ops
  always_ff @(posedge clk) begin
    if (pe_op == 2'b00)
      pe_out <= (pe_acc_en ? pe_out : ACC_W'(pe_z))
              + ACC_W'(pe_x) * ACC_W'(pe_y);
    else
      pe_out <= (pe_first_cycle ? ACC_W'(pe_x) : (pe_out << 1))
              + ACC_W'(pe_coeff)
              + (pe_last_cycle ? ACC_W'(pe_y) : '0);
  end

  int total = 0;
  int bad   = 0;
  logic [ACC_W-1:0]  exp_q [$];
  logic [ACC_W-1:0]  e;
  logic [ACC_W-1:0]  cap;
  logic [MAC_BW-1:0] c [MAX_TERMS];
  bit                ok;
  int                steps;
  bit                seen;

  // Reference result of n PE steps with coefficients c
  function automatic logic [ACC_W-1:0] poly_ref(
    input logic [MAC_BW-1:0] x,
    input logic [MAC_BW-1:0] y,
    input int n,
    input logic [MAC_BW-1:0] cf [MAX_TERMS]
  );
    logic [ACC_W-1:0] a;
    a = '0;
    for (int i = 0; i < n; i++) begin
      a = ((i == 0) ? ACC_W'(x) : (a << 1)) + ACC_W'(cf[i]);
      if (i == n-1) a = a + ACC_W'(y);
    end
    return a;
  endfunction

  task automatic cfg_write(input logic we, input logic lwe,
                           input logic [1:0] op, input logic [2:0] idx,
                           input logic [MAC_BW-1:0] d);
    cfg_we = we; cfg_len_we = lwe;
    cfg_op = op; cfg_idx = idx; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0; cfg_len_we = 1'b0;
  endtask

  task automatic send_req(input logic [1:0] op,
                          input logic [MAC_BW-1:0] x,
                          input logic [MAC_BW-1:0] y,
                          input logic [2*MAC_BW-1:0] z,
                          input logic last);
    bus.req_valid = 1'b1; bus.req_op = op;
    bus.req_x = x; bus.req_y = y; bus.req_z = z; bus.req_last = last;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_last = 1'b0;
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic ack_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++; $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready);
    end
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready);
    end
    total++;
    if (bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid);
    end
    total++;
    if (pe_first_cycle !== 1'b0 || pe_last_cycle !== 1'b0) begin
      bad++; $display("FAIL rst_flags: got %b%b want 00",
                      pe_first_cycle, pe_last_cycle);
    end
    total++;
    if (bus.rsp_data !== '0) begin
      bad++; $display("FAIL rst_rsp_data: got %0h want 0", bus.rsp_data);
    end
  endtask

  task automatic test_mac();
    exp_q.push_back(ACC_W'(10 + 2*3 + 4*5 + 1*1));
    bus.req_valid = 1'b1; bus.req_op = 2'b00;
    bus.req_x = 2; bus.req_y = 3; bus.req_z = 10; bus.req_last = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    total++;
    if (pe_acc_en !== 1'b0 || pe_x !== 12'd2 || pe_z !== 24'd10) begin
      bad++; $display("FAIL mac_beat1: acc_en=%b x=%0d z=%0d want 0 2 10",
                      pe_acc_en, pe_x, pe_z);
    end
    @(negedge clk);
    total++;
    if (pe_acc_en !== 1'b1 || pe_x !== 12'd0 || pe_y !== 12'd0) begin
      bad++; $display("FAIL mac_gap: acc_en=%b x=%0d y=%0d want 1 0 0",
                      pe_acc_en, pe_x, pe_y);
    end
    bus.req_valid = 1'b1; bus.req_x = 4; bus.req_y = 5;
    @(negedge clk);
    total++;
    if (pe_acc_en !== 1'b1 || pe_x !== 12'd4) begin
      bad++; $display("FAIL mac_beat2: acc_en=%b x=%0d want 1 4",
                      pe_acc_en, pe_x);
    end
    bus.req_x = 1; bus.req_y = 1; bus.req_last = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_last = 1'b0;
    total++;
    if (pe_acc_en !== 1'b1 || pe_x !== 12'd1 || bus.req_ready !== 1'b0) begin
      bad++; $display("FAIL mac_beat3: acc_en=%b x=%0d rdy=%b want 1 1 0",
                      pe_acc_en, pe_x, bus.req_ready);
    end
    wait_rsp(ok);
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++; $display("FAIL mac_rsp: valid=%b want 1", bus.rsp_valid);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (bus.rsp_data !== e) begin
        bad++; $display("FAIL mac_data: got %0d want %0d", bus.rsp_data, e);
      end
    end
    ack_rsp();
  endtask

  task automatic test_exp();
    cfg_write(1'b0, 1'b1, 2'b10, 3'd0, 12'd4);
    c = '{default: '0};
    c[0] = 12'h100; c[1] = 12'h080; c[2] = 12'h040; c[3] = 12'h020;
    for (int i = 0; i < 4; i++) cfg_write(1'b1, 1'b0, 2'b10, 3'(i), c[i]);
    exp_q.push_back(poly_ref(12'd3, 12'd5, 4, c));
    send_req(2'b10, 12'd3, 12'd5, '0, 1'b0);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      total++;
      if (pe_coeff !== c[cyc-1] || pe_first_cycle !== (cyc == 1)
          || pe_last_cycle !== (cyc == 4) || bus.req_ready !== 1'b0) begin
        bad++;
        $display("FAIL exp_step%0d: coeff=%0h f=%b l=%b rdy=%b want %0h %b %b 0",
                 cyc, pe_coeff, pe_first_cycle, pe_last_cycle, bus.req_ready,
                 c[cyc-1], cyc == 1, cyc == 4);
      end
      @(negedge clk);
    end
    total++;
    if (bus.rsp_valid !== 1'b0 || pe_first_cycle !== 1'b0
        || pe_last_cycle !== 1'b0) begin
      bad++; $display("FAIL exp_capt: valid=%b f=%b l=%b want 0 0 0",
                      bus.rsp_valid, pe_first_cycle, pe_last_cycle);
    end
    cap = pe_out;
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== cap) begin
      bad++; $display("FAIL exp_cycle6: valid=%b data=%0h want 1 %0h",
                      bus.rsp_valid, bus.rsp_data, cap);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (bus.rsp_data !== e) begin
        bad++; $display("FAIL exp_data: got %0h want %0h", bus.rsp_data, e);
      end
    end
    ack_rsp();
  endtask

  task automatic test_backpressure();
    c = '{default: '0};
    exp_q.push_back(poly_ref(12'd7, 12'd9, 2, c));
    send_req(2'b01, 12'd7, 12'd9, '0, 1'b0);
    wait_rsp(ok);
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++; $display("FAIL bp_rsp: valid=%b want 1", bus.rsp_valid);
    end else begin
      e = exp_q.pop_front();
      bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_x = 2;
      bus.req_y = 2; bus.req_z = 100; bus.req_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== e
            || bus.req_ready !== 1'b0) begin
          bad++;
          $display("FAIL bp_hold%0d: valid=%b data=%0h rdy=%b want 1 %0h 0",
                   i, bus.rsp_valid, bus.rsp_data, bus.req_ready, e);
        end
        @(negedge clk);
      end
      exp_q.push_back(ACC_W'(100 + 2*2));
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      total++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        bad++; $display("FAIL bp_release: valid=%b rdy=%b want 0 1",
                        bus.rsp_valid, bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = 1'b0; bus.req_last = 1'b0;
      total++;
      if (bus.req_ready !== 1'b0 || pe_z !== 24'd100) begin
        bad++; $display("FAIL bp_accept: rdy=%b z=%0d want 0 100",
                        bus.req_ready, pe_z);
      end
      wait_rsp(ok);
      total++;
      if (!ok || exp_q.size() == 0) begin
        bad++; $display("FAIL bp_rsp2: valid=%b want 1", bus.rsp_valid);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (bus.rsp_data !== e) begin
          bad++; $display("FAIL bp_data2: got %0d want %0d", bus.rsp_data, e);
        end
      end
    end
    ack_rsp();
  endtask

  task automatic test_rst_mid();
    send_req(2'b10, 12'd3, 12'd5, '0, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if (pe_coeff !== 12'h040) begin
      bad++; $display("FAIL rm_step2: coeff=%0h want 40", pe_coeff);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (cfg_ready !== 1'b1 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0
        || pe_first_cycle !== 1'b0 || pe_last_cycle !== 1'b0
        || pe_coeff !== '0) begin
      bad++; $display("FAIL rm_idle: cfg=%b rdy=%b valid=%b f=%b l=%b coeff=%0h",
                      cfg_ready, bus.req_ready, bus.rsp_valid,
                      pe_first_cycle, pe_last_cycle, pe_coeff);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL rm_no_rsp: rsp_valid seen=%b want 0", seen);
    end
    c = '{default: '0};
    exp_q.push_back(poly_ref(12'd3, 12'd5, 2, c));
    send_req(2'b10, 12'd3, 12'd5, '0, 1'b0);
    total++;
    if (pe_coeff !== '0 || pe_first_cycle !== 1'b1) begin
      bad++; $display("FAIL rm_tab: coeff=%0h f=%b want 0 1",
                      pe_coeff, pe_first_cycle);
    end
    @(negedge clk);
    total++;
    if (pe_last_cycle !== 1'b1) begin
      bad++; $display("FAIL rm_len: last=%b want 1", pe_last_cycle);
    end
    wait_rsp(ok);
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++; $display("FAIL rm_rsp: valid=%b want 1", bus.rsp_valid);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (bus.rsp_data !== e) begin
        bad++; $display("FAIL rm_data: got %0d want %0d", bus.rsp_data, e);
      end
    end
    ack_rsp();
  endtask

  task automatic test_cfg_busy();
    c = '{default: '0};
    exp_q.push_back(poly_ref(12'd7, 12'd9, 2, c));
    exp_q.push_back(poly_ref(12'd7, 12'd9, 2, c));
    send_req(2'b01, 12'd7, 12'd9, '0, 1'b0);
    total++;
    if (cfg_ready !== 1'b0) begin
      bad++; $display("FAIL cb_ready: got %b want 0", cfg_ready);
    end
    cfg_write(1'b1, 1'b1, 2'b01, 3'd1, 12'h005);
    for (int r = 0; r < 2; r++) begin
      if (r == 1) send_req(2'b01, 12'd7, 12'd9, '0, 1'b0);
      wait_rsp(ok);
      total++;
      if (!ok || exp_q.size() == 0) begin
        bad++; $display("FAIL cb_rsp%0d: valid=%b want 1", r, bus.rsp_valid);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (bus.rsp_data !== e) begin
          bad++; $display("FAIL cb_data%0d: got %0d want %0d",
                          r, bus.rsp_data, e);
        end
      end
      ack_rsp();
    end
    for (int t = 0; t < 2; t++) begin
      c = '{default: '0};
      if (t == 0) begin
        cfg_write(1'b1, 1'b1, 2'b01, 3'd0, 12'h001);
        c[0] = 12'h001;
        exp_q.push_back(poly_ref(12'd7, 12'd9, 2, c));
        send_req(2'b01, 12'd7, 12'd9, '0, 1'b0);
      end else begin
        cfg_write(1'b0, 1'b1, 2'b11, 3'd0, 12'h00F);
        exp_q.push_back(poly_ref(12'd1, 12'd0, MAX_TERMS, c));
        send_req(2'b11, 12'd1, 12'd0, '0, 1'b0);
      end
      steps = 0;
      for (int i = 0; i < 20; i++) begin
        if (pe_op != 2'b00) steps++;
        if (pe_last_cycle === 1'b1) break;
        @(negedge clk);
      end
      total++;
      if (steps != ((t == 0) ? 2 : MAX_TERMS)) begin
        bad++; $display("FAIL cb_steps%0d: got %0d want %0d",
                        t, steps, (t == 0) ? 2 : MAX_TERMS);
      end
      wait_rsp(ok);
      total++;
      if (!ok || exp_q.size() == 0) begin
        bad++; $display("FAIL cb_len_rsp%0d: valid=%b want 1",
                        t, bus.rsp_valid);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (bus.rsp_data !== e) begin
          bad++; $display("FAIL cb_len_data%0d: got %0d want %0d",
                          t, bus.rsp_data, e);
        end
      end
      ack_rsp();
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_z     = '0;
    bus.req_last  = 1'b0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_mac();
    test_exp();
    test_backpressure();
    test_rst_mid();
    test_cfg_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
